rcs64_serial_sub: RTL
=====================

// Module: rcs64_serial_sub
// PURPOSE
//  Multi-cycle ripple-borrow subtractor: the inverse datapath to the 64-bit ripple-carry adder.
//  - Computes diff = op1 - op2 - bin, CHUNK bits per clock, LSB chunk first.
//  - Uses a start/busy/done handshake.
//  - Sits beside the adder in the arithmetic unit. A bench pairs the two blocks so that diff + op2 reproduces op1.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits subtracted per clock; NCH = WIDTH/CHUNK chunk cycles
// PORTS
//  clock  in   1      single clock, rising-edge
//  reset  in   1      asynchronous, active-high; clears all state and outputs
//  start  in   1      request; sampled only in IDLE or DONE
//  op1    in   WIDTH  minuend, captured on accepted start
//  op2    in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse; diff/brout/ovf valid from this cycle
//  diff   out  WIDTH  result; held until the next completion
//  brout  out  1      borrow out of MSB (1 iff op1 < op2 + bin, unsigned)
//  ovf    out  1      signed overflow: op1[MSB]!=op2[MSB] && diff[MSB]!=op1[MSB]
// BEHAVIOUR
//  - Reset values: state=IDLE, busy=0, done=0, diff=0, brout=0, ovf=0. Internal regs and chunk counter are 0.
//  - FSM states:
//    - IDLE: start=1 -> RUN. Capture op1, op2 and bin into working regs; counter=0; borrow=bin.
//    - RUN: each edge subtracts chunk[counter] with the running borrow, writes that chunk into the accumulator, updates borrow and increments counter.
//      After chunk NCH-1 -> DONE. Copy accumulator to diff, final borrow to brout, and compute ovf.
//    - DONE: done=1 for exactly this cycle. start=1 -> RUN (back-to-back, captured as in IDLE); else -> IDLE.
//  - Latency: start sampled at edge E -> done high in the cycle after edge E+NCH (NCH clocks; 8 for defaults).
//  - start in RUN is ignored, with no queueing; operands and bin are don't-care outside the accepting edge.
//  - Outputs diff/brout/ovf change only on entry to DONE, never mid-operation. Partial results are never visible.
//  - Arithmetic is modulo 2^WIDTH, with no saturation.
//    - op1=op2, bin=0 -> diff=0, brout=0.
//    - op1=0, op2=0, bin=1 -> diff=all ones, brout=1.
//  - Reset asserted mid-RUN aborts at once: no done pulse, outputs return to reset values.
//    A start after reset release runs normally.
//  - Reset and start together: reset wins.
// STRUCTURE
//  - Shared package/include rcs_pkg: state encoding localparams (S_IDLE, S_RUN, S_DONE) and the NCH derivation.
//  - Counter width is clog2(NCH).
//  - One sub-module, sub_chunk: combinational CHUNK-bit ripple-borrow subtractor built from full-subtractor cells.
//    Ports: a, b, bin -> d, bout. Instantiated once and indexed by counter.
//  - Top level holds the FSM, counter, working/accumulator regs and output regs.
// TESTING
//  (clock period 24 ns, reset high for the first 4 ns; assert on the done pulse)
//  1. Reset only -> busy=0, done=0, diff=0, brout=0, ovf=0. Held while no start.
//  2. op1=FFFF_FFFF_FFFF_FFFF, op2=EEEE_DDDD_CCCC_FFFF, bin=0, start 1 cycle
//     -> busy high 8 cycles; then done=1 for 1 cycle with diff=1111_2222_3333_0000, brout=0, ovf=0.
//  3. op1=0, op2=1 -> diff=FFFF_FFFF_FFFF_FFFF, brout=1, ovf=0.
//     Then op1=8000_0000_0000_0000, op2=1 -> diff=7FFF_FFFF_FFFF_FFFF, brout=0, ovf=1.
//  4. Assert reset during chunk 4 of a run -> outputs drop to 0 and no done pulse.
//     Then a fresh start with op1=10, op2=3 -> diff=7 after 8 cycles.
//  5. Pulse start again in mid-RUN with different operands -> ignored; the original result is reported.
//     Start held in DONE -> back-to-back run, with done exactly 8 cycles later.
//  6. Cross-check vs RCA64 over 200 random pairs with bin=0: feed diff and op2 into the adder
//     -> sum==op1 and crout==brout for every pair.

Source files
------------

// File: rtl/rcs_pkg.sv
// Shared definitions for the serial ripple-borrow subtractor: state encoding and chunk math.
package rcs_pkg;

    // State encoding, kept as named constants so the arithmetic unit can decode them.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } rcs_state_t;

    // Number of chunk cycles for a given operand width and chunk size.
    function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Counter width; never zero, even for a single-chunk configuration.
    function automatic int unsigned calc_cw(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor built from full-subtractor cells.
module sub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] br;

    assign br[0] = bin;

    // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign d[i]    = a[i] ^ b[i] ^ br[i];
        assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign bout = br[CHUNK];

endmodule

// File: rtl/rcs64_serial_sub.sv
// Multi-cycle subtractor: diff = op1 - op2 - bin, one CHUNK per clock, LSB chunk first.
module rcs64_serial_sub
    import rcs_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brout,
    output logic             ovf
);

    localparam int unsigned NCH = calc_nch(WIDTH, CHUNK);
    localparam int unsigned CW  = calc_cw(NCH);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCH - 1);

    rcs_state_t state_q, state_d;

    logic [WIDTH-1:0] op1_q, op2_q, acc_q, acc_next;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             brout_q, ovf_q;

    logic [CHUNK-1:0] ch_a, ch_b, ch_d;
    logic             ch_bout;
    logic             accept;
    logic             last_chunk;

    // Single subtractor slice, steered to the active chunk by the counter.
    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .bin  (borrow_q),
        .d    (ch_d),
        .bout (ch_bout)
    );

    // Select the active chunk of each operand and merge the new result chunk into the accumulator.
    always_comb begin
        ch_a     = op1_q[int'(cnt_q) * CHUNK +: CHUNK];
        ch_b     = op2_q[int'(cnt_q) * CHUNK +: CHUNK];
        acc_next = acc_q;
        acc_next[int'(cnt_q) * CHUNK +: CHUNK] = ch_d;
    end

    assign last_chunk = (cnt_q == CNT_LAST);
    assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers, accumulator, borrow and chunk counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            op1_q    <= op1;
            op2_q    <= op2;
            acc_q    <= '0;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (state_q == ST_RUN) begin
            acc_q    <= acc_next;
            borrow_q <= ch_bout;
            cnt_q    <= last_chunk ? '0 : cnt_q + 1'b1;
        end
    end

    // Result registers; updated only on the edge that enters DONE so partials never show.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            diff_q  <= '0;
            brout_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_RUN && last_chunk) begin
            diff_q  <= acc_next;
            brout_q <= ch_bout;
            ovf_q   <= (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (acc_next[WIDTH-1] != op1_q[WIDTH-1]);
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign brout = brout_q;
    assign ovf   = ovf_q;

endmodule
